// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared definitions for the UART TX arbiter.
//   arb_state_e - arbiter FSM state (IDLE: no owner, ACTIVE: one source owns the stream)
//   idx_width   - bit width needed to hold an index in 0..n-1 (never less than 1)
package uart_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle of the requester-side AXI-stream bus, the UART-side
// AXI-stream bus and the grant status of the arbiter.
//   s_axis_*    - PORTS requesters, byte i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*    - single stream towards the uart_tx instance
//   grant*      - one-hot grant, grant-active flag, current/last grant index
// Modports: slave = the arbiter, master = the surrounding requesters/UART side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) ();

    localparam int IW = idx_width(PORTS);

    logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS-1:0]            s_axis_tvalid;
    logic [PORTS-1:0]            s_axis_tready;
    logic [PORTS-1:0]            s_axis_tlast;
    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;
    logic [PORTS-1:0]            grant;
    logic                        grant_valid;
    logic [IW-1:0]               grant_index;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output grant, grant_valid, grant_index
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  grant, grant_valid, grant_index
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// arbiter_rr: combinational round-robin priority select.
//   i_req - request vector
//   i_ptr - index of the last winner; search starts at i_ptr+1 and wraps
//   o_gnt - one-hot winner (zero when no request)
//   o_idx - index of the winner (zero when no request)
//   o_any - at least one request present
module arbiter_rr
    import uart_arb_pkg::*;
#(
    parameter int PORTS = 4,
    localparam int IW   = idx_width(PORTS)
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [PORTS-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    // Cyclic search: offset i visits port (ptr+i) mod PORTS; first requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            int  j;
            j = (int'(i_ptr) + i) % PORTS;
            for (int p = 0; p < PORTS; p++) begin
                logic w_hit;
                w_hit    = (p == j) && i_req[p] && !o_any;
                o_gnt[p] = o_gnt[p] | w_hit;
                o_idx    = w_hit ? IW'(p) : o_idx;
                o_any    = o_any | w_hit;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte stream between PORTS sources with
// round-robin arbitration and packet lock (grant held until tlast, or until
// MAX_BURST accepted beats when MAX_BURST > 0).
//   clk     - core clock, rising edge
//   reset_n - synchronous active-low reset
//   axis    - uart_tx_arbiter_if.slave: requester bus, UART bus, grant status
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_arbiter_if.slave   axis
);

    localparam int IW = idx_width(PORTS);

    arb_state_e            r_state, w_state_nxt;
    logic [PORTS-1:0]      r_grant, w_grant_nxt;
    logic                  r_grant_valid, w_grant_valid_nxt;
    logic [IW-1:0]         r_grant_index, w_grant_index_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                  r_m_tvalid, w_m_tvalid_nxt;
    logic [DATA_WIDTH-1:0] r_m_tdata, w_m_tdata_nxt;
    logic                  r_m_tlast, w_m_tlast_nxt;

    logic [PORTS-1:0]      w_arb_gnt;
    logic [IW-1:0]         w_arb_idx;
    logic                  w_arb_any;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid, w_sel_last;
    logic                  w_out_free, w_s_hs, w_burst_hit, w_release;
    logic [PORTS-1:0]      w_tready;

    // The pointer is the last grant index, so the search starts just after it.
    arbiter_rr #(.PORTS(PORTS)) u_rr (
        .i_req (axis.s_axis_tvalid),
        .i_ptr (r_grant_index),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Granted-source mux, source ready, handshake and release decode.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_tready    = '0;
        w_out_free  = !r_m_tvalid || axis.m_axis_tready;
        for (int p = 0; p < PORTS; p++) begin
            logic w_is_g;
            w_is_g      = (IW'(p) == r_grant_index);
            w_sel_data  = w_is_g ? axis.s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH] : w_sel_data;
            w_sel_valid = w_is_g ? axis.s_axis_tvalid[p] : w_sel_valid;
            w_sel_last  = w_is_g ? axis.s_axis_tlast[p] : w_sel_last;
            w_tready[p] = w_is_g && (r_state == ACTIVE) && w_out_free;
        end
        w_s_hs      = (r_state == ACTIVE) && w_sel_valid && w_out_free;
        // Saturating increment keeps the counter from wrapping when unlimited.
        w_cnt_inc   = (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + CNT_WIDTH'(1);
        w_burst_hit = (MAX_BURST != 0) && (w_cnt_inc == CNT_WIDTH'(MAX_BURST));
        w_release   = w_s_hs && (w_sel_last || w_burst_hit);
    end

    // Next-state logic: FSM, grant, burst counter and output register.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_index_nxt = r_grant_index;
        w_cnt_nxt         = r_cnt;
        w_m_tvalid_nxt    = r_m_tvalid;
        w_m_tdata_nxt     = r_m_tdata;
        w_m_tlast_nxt     = r_m_tlast;

        // Output register drains in either state; it only loads on a source beat.
        if (w_s_hs) begin
            w_m_tvalid_nxt = 1'b1;
            w_m_tdata_nxt  = w_sel_data;
            w_m_tlast_nxt  = w_sel_last;
        end else if (axis.m_axis_tready) begin
            w_m_tvalid_nxt = 1'b0;
        end else begin
            w_m_tvalid_nxt = r_m_tvalid;
        end

        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_state_nxt       = ACTIVE;
                    w_grant_nxt       = w_arb_gnt;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_index_nxt = w_arb_idx;
                    w_cnt_nxt         = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACTIVE: begin
                // grant_index is kept on release: it is the next search pointer.
                if (w_release) begin
                    w_state_nxt       = IDLE;
                    w_grant_nxt       = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_cnt_nxt         = '0;
                end else if (w_s_hs) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt       = IDLE;
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
                w_cnt_nxt         = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_index <= IW'(PORTS - 1);
            r_cnt         <= '0;
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_m_tlast     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_index <= w_grant_index_nxt;
            r_cnt         <= w_cnt_nxt;
            r_m_tvalid    <= w_m_tvalid_nxt;
            r_m_tdata     <= w_m_tdata_nxt;
            r_m_tlast     <= w_m_tlast_nxt;
        end
    end

    assign axis.s_axis_tready = w_tready;
    assign axis.m_axis_tdata  = r_m_tdata;
    assign axis.m_axis_tvalid = r_m_tvalid;
    assign axis.m_axis_tlast  = r_m_tlast;
    assign axis.grant         = r_grant;
    assign axis.grant_valid   = r_grant_valid;
    assign axis.grant_index   = r_grant_index;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances in lockstep (unlimited burst and
// MAX_BURST=2) fed from per-port message queues, compared each cycle against a
// behavioural model of owner / pointer / held output beat.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int P  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n = 1'b0;
    logic            m_tready = 1'b0;
    logic [P-1:0]    s_tvalid [2];
    logic [P*DW-1:0] s_tdata  [2];
    logic [P-1:0]    s_tlast  [2];

    logic [P-1:0]  o_tready [2];
    logic [P-1:0]  o_grant  [2];
    logic          o_gv     [2];
    logic [1:0]    o_gi     [2];
    logic          o_mv     [2];
    logic [DW-1:0] o_md     [2];
    logic          o_ml     [2];

    uart_tx_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) if0 ();
    uart_tx_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) if1 ();

    assign if0.s_axis_tvalid = s_tvalid[0];
    assign if0.s_axis_tdata  = s_tdata[0];
    assign if0.s_axis_tlast  = s_tlast[0];
    assign if0.m_axis_tready = m_tready;
    assign if1.s_axis_tvalid = s_tvalid[1];
    assign if1.s_axis_tdata  = s_tdata[1];
    assign if1.s_axis_tlast  = s_tlast[1];
    assign if1.m_axis_tready = m_tready;

    assign o_tready[0] = if0.s_axis_tready;  assign o_tready[1] = if1.s_axis_tready;
    assign o_grant[0]  = if0.grant;          assign o_grant[1]  = if1.grant;
    assign o_gv[0]     = if0.grant_valid;    assign o_gv[1]     = if1.grant_valid;
    assign o_gi[0]     = if0.grant_index;    assign o_gi[1]     = if1.grant_index;
    assign o_mv[0]     = if0.m_axis_tvalid;  assign o_mv[1]     = if1.m_axis_tvalid;
    assign o_md[0]     = if0.m_axis_tdata;   assign o_md[1]     = if1.m_axis_tdata;
    assign o_ml[0]     = if0.m_axis_tlast;   assign o_ml[1]     = if1.m_axis_tlast;

    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .MAX_BURST(0), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .reset_n(reset_n), .axis(if0));
    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .MAX_BURST(2), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .axis(if1));

    // Behavioural model: who owns the stream, the rr pointer, beats in this grant,
    // and the beat sitting in the output slot.
    int         md_owner [2];
    int         md_ptr   [2];
    int         md_beats [2];
    bit         md_ov    [2];
    logic [7:0] md_od    [2];
    bit         md_ol    [2];
    int         mb       [2];

    logic [8:0] src_q    [2][P][$];
    bit         en       [2][P];
    int         acc_log  [2][$];
    logic [8:0] emit_log [2][$];
    int         pushed   [2];
    int         emitted  [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(int k);
        md_owner[k] = -1;
        md_ptr[k]   = P - 1;
        md_beats[k] = 0;
        md_ov[k]    = 1'b0;
        md_od[k]    = 8'h00;
        md_ol[k]    = 1'b0;
    endtask

    task automatic check_regs(int k);
        logic [P-1:0] eg;
        eg = (md_owner[k] < 0) ? '0 : (P'(1) << md_owner[k]);
        chk("grant", k, o_grant[k], eg);
        chk("grant_valid", k, o_gv[k], md_owner[k] >= 0);
        chk("grant_index", k, o_gi[k], md_ptr[k]);
        chk("m_tvalid", k, o_mv[k], md_ov[k]);
        chk("m_tdata", k, o_md[k], md_od[k]);
        chk("m_tlast", k, o_ml[k], md_ol[k]);
    endtask

    task automatic drive(int k);
        logic [P-1:0]    v, l;
        logic [P*DW-1:0] d;
        logic [8:0]      b;
        for (int p = 0; p < P; p++) begin
            if (src_q[k][p].size() > 0) begin
                b = src_q[k][p][0];
                d[p*DW +: DW] = b[7:0];
                l[p] = b[8];
                v[p] = en[k][p];
            end else begin
                d[p*DW +: DW] = 8'($urandom);
                l[p] = 1'($urandom);
                v[p] = 1'b0;
            end
        end
        s_tvalid[k] = v;
        s_tdata[k]  = d;
        s_tlast[k]  = l;
    endtask

    // Advance the model across the coming rising edge.
    task automatic step(int k, bit mrdy, bit rstn);
        logic [P-1:0] etr;
        logic [8:0]   b;
        if (!rstn) begin
            model_reset(k);
            return;
        end
        etr = (md_owner[k] >= 0 && (!md_ov[k] || mrdy)) ? (P'(1) << md_owner[k]) : '0;
        chk("s_tready", k, o_tready[k], etr);
        if (md_ov[k] && mrdy) begin
            emit_log[k].push_back({md_ol[k], md_od[k]});
            emitted[k]++;
        end
        if (md_owner[k] < 0) begin
            if (md_ov[k] && mrdy) md_ov[k] = 1'b0;
            if (|s_tvalid[k]) begin
                for (int i = 1; i <= P; i++) begin
                    int j;
                    j = (md_ptr[k] + i) % P;
                    if (md_owner[k] < 0 && s_tvalid[k][j]) md_owner[k] = j;
                end
                md_ptr[k]   = md_owner[k];
                md_beats[k] = 0;
            end
        end else if (s_tvalid[k][md_owner[k]] && etr != '0) begin
            b = src_q[k][md_owner[k]].pop_front();
            md_od[k] = b[7:0];
            md_ol[k] = b[8];
            md_ov[k] = 1'b1;
            acc_log[k].push_back(md_owner[k]);
            if (md_beats[k] < 255) md_beats[k]++;
            if (b[8] || (mb[k] > 0 && md_beats[k] == mb[k])) begin
                md_owner[k] = -1;
                md_beats[k] = 0;
            end
        end else if (mrdy) begin
            md_ov[k] = 1'b0;
        end
    endtask

    task automatic cycle(bit mrdy, bit rstn);
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_regs(k);
        reset_n  = rstn;
        m_tready = mrdy;
        for (int k = 0; k < 2; k++) drive(k);
        #1;
        for (int k = 0; k < 2; k++) step(k, mrdy, rstn);
    endtask

    function automatic bit idle(int k);
        bit r;
        r = (md_owner[k] < 0) && !md_ov[k];
        for (int p = 0; p < P; p++) if (src_q[k][p].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_until_idle(int budget);
        int n;
        n = 0;
        for (int k = 0; k < 2; k++) for (int p = 0; p < P; p++) en[k][p] = 1'b1;
        while (!(idle(0) && idle(1)) && n < budget) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        chk("drain_within_budget", 0, n < budget, 1'b1);
        cycle(1'b1, 1'b1);
    endtask

    task automatic push_msg(int p, int n, logic [7:0] base);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < n; i++) src_q[k][p].push_back({(i == n - 1), 8'(int'(base) + i)});
            pushed[k] += n;
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            acc_log[k].delete();
            emit_log[k].delete();
        end
    endtask

    task automatic chk_acc(string nm, int k, int e[$]);
        chk(nm, k, acc_log[k].size(), e.size());
        for (int i = 0; i < e.size() && i < acc_log[k].size(); i++) chk(nm, k, acc_log[k][i], e[i]);
    endtask

    task automatic chk_emit(string nm, int k, logic [8:0] e[$]);
        chk(nm, k, emit_log[k].size(), e.size());
        for (int i = 0; i < e.size() && i < emit_log[k].size(); i++) chk(nm, k, emit_log[k][i], e[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int         ea[$];
        logic [8:0] ee[$];
        int         budget;
        mb[0] = 0;
        mb[1] = 2;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            pushed[k]  = 0;
            emitted[k] = 0;
            for (int p = 0; p < P; p++) en[k][p] = 1'b1;
            s_tvalid[k] = '0;
            s_tdata[k]  = '0;
            s_tlast[k]  = '0;
        end

        // Reset values
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        chk("reset_grant_index", 0, o_gi[0], 2'd3);
        chk("reset_m_tvalid", 0, o_mv[0], 1'b0);

        // Single source, port 2
        clear_logs();
        push_msg(2, 3, 8'h41);
        cycle(1'b1, 1'b1);
        @(posedge clk); #1;
        chk("grant_latency", 0, o_gv[0], 1'b1);
        chk("grant_is_p2", 0, o_grant[0], 4'b0100);
        run_until_idle(40);
        ee = '{9'h041, 9'h042, 9'h143};
        chk_emit("single_bytes", 0, ee);
        chk("single_idx_kept", 0, o_gi[0], 2'd2);
        chk("single_released", 0, o_gv[0], 1'b0);

        // Contention: pointer at 2 -> 3, 0, 1 ... use fresh reset for port-0 priority
        cycle(1'b1, 1'b0);
        clear_logs();
        push_msg(0, 2, 8'h10);
        push_msg(1, 2, 8'h20);
        push_msg(3, 2, 8'h30);
        run_until_idle(60);
        ea = '{0, 0, 1, 1, 3, 3};
        chk_acc("contention_order", 0, ea);
        chk_acc("contention_order", 1, ea);

        // Fairness: 40 one-byte messages
        clear_logs();
        for (int r = 0; r < 10; r++)
            for (int p = 0; p < P; p++) push_msg(p, 1, 8'(r * 4 + p));
        run_until_idle(400);
        ea.delete();
        for (int i = 0; i < 40; i++) ea.push_back(i % 4);
        chk_acc("fairness_order", 0, ea);

        // Burst limit on dut1
        clear_logs();
        push_msg(0, 5, 8'h50);
        push_msg(1, 1, 8'h60);
        run_until_idle(80);
        ea = '{0, 0, 1, 0, 0, 0};
        chk_acc("burst_order", 1, ea);
        ee = '{9'h050, 9'h051, 9'h160, 9'h052, 9'h053, 9'h154};
        chk_emit("burst_bytes", 1, ee);
        ea = '{0, 0, 0, 0, 0, 1};
        chk_acc("noburst_order", 0, ea);

        // Backpressure during a 4-byte message
        clear_logs();
        push_msg(3, 4, 8'h70);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        run_until_idle(60);
        ee = '{9'h070, 9'h071, 9'h072, 9'h173};
        chk_emit("backpressure_bytes", 0, ee);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, P - 1);
                if (src_q[0][p].size() < 20) push_msg(p, $urandom_range(1, 6), 8'($urandom));
            end
            for (int p = 0; p < P; p++) begin
                bit e;
                e = ($urandom_range(0, 3) != 0);
                en[0][p] = e;
                en[1][p] = e;
            end
            cycle($urandom_range(0, 9) < 7, 1'b1);
        end
        run_until_idle(2000);
        chk("no_loss", 0, emitted[0], pushed[0]);
        chk("no_loss", 1, emitted[1], pushed[1]);

        // Reset in the middle of a message from port 1
        clear_logs();
        push_msg(1, 4, 8'h80);
        budget = 0;
        while (acc_log[0].size() < 2 && budget < 50) begin
            cycle(1'b1, 1'b1);
            budget++;
        end
        chk("midreset_reached", 0, budget < 50, 1'b1);
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) for (int p = 0; p < P; p++) src_q[k][p].delete();
        @(posedge clk); #1;
        chk("midreset_gv", 0, o_gv[0], 1'b0);
        chk("midreset_mv", 0, o_mv[0], 1'b0);
        chk("midreset_ml", 0, o_ml[0], 1'b0);
        chk("midreset_gi", 0, o_gi[0], 2'd3);
        clear_logs();
        push_msg(3, 1, 8'hA0);
        push_msg(0, 1, 8'h90);
        run_until_idle(40);
        ea = '{0, 3};
        chk_acc("after_reset_order", 0, ea);
        ee = '{9'h190, 9'h1A0};
        chk_emit("after_reset_bytes", 0, ee);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
